// File: rtl/peak_pkg.sv
// Shared constants and types for the peak tracker.
// Holds the default widths, the state encoding and an index-width helper.
package peak_pkg;

  localparam int DATLEN_DEF = 12;
  localparam int NBINS_DEF  = 64;
  localparam int NCH_DEF    = 2;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index width for n entries, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BIN_W_DEF = idx_w(NBINS_DEF);
  localparam int CH_W_DEF  = idx_w(NCH_DEF);

endpackage

// File: rtl/peak_cmp.sv
// Window test plus strict unsigned compare-and-update for one sample.
// Ports: bin/data in, cur_max/cur_pbin in, nxt_max/nxt_pbin out.
module peak_cmp
  import peak_pkg::*;
#(
  parameter int DATLEN = DATLEN_DEF,
  parameter int BW     = BIN_W_DEF,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 31
) (
  input  logic [BW-1:0]     bin,
  input  logic [DATLEN-1:0] data,
  input  logic [DATLEN-1:0] cur_max,
  input  logic [BW-1:0]     cur_pbin,
  output logic [DATLEN-1:0] nxt_max,
  output logic [BW-1:0]     nxt_pbin
);

  logic in_win;
  logic gt;

  // Signed int compare keeps a zero lower bound well defined.
  always_comb begin
    in_win   = (int'(bin) >= BIN_LO) && (int'(bin) <= BIN_HI);
    gt       = in_win && (data > cur_max);
    nxt_max  = gt ? data : cur_max;
    nxt_pbin = gt ? bin  : cur_pbin;
  end

endmodule

// File: rtl/peak_track.sv
// Per-frame peak magnitude tracker over an FFT bin window, per channel.
// Ports: clk, reset_n, in_data/nd/sof/ovf in; out_max/bin/ch/ovf/valid, frame_err out.
module peak_track
  import peak_pkg::*;
#(
  parameter int DATLEN = DATLEN_DEF,
  parameter int NBINS  = NBINS_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = NBINS / 2 - 1,
  localparam int BW    = idx_w(NBINS),
  localparam int CW    = idx_w(NCH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATLEN-1:0] in_data,
  input  logic              in_nd,
  input  logic              in_sof,
  input  logic              in_ovf,
  output logic [DATLEN-1:0] out_max,
  output logic [BW-1:0]     out_bin,
  output logic [CW-1:0]     out_ch,
  output logic              out_ovf,
  output logic              out_valid,
  output logic              frame_err
);

  state_t            state;
  logic [BW-1:0]     bin;
  logic [CW-1:0]     ch;
  logic [DATLEN-1:0] max_q;
  logic [BW-1:0]     pbin;
  logic              ovf;

  logic              accept;
  logic              abort;
  logic              first;
  logic              last;
  logic [BW-1:0]     eff_bin;
  logic [CW-1:0]     eff_ch;
  logic [CW-1:0]     inc_ch;
  logic [DATLEN-1:0] base_max;
  logic [BW-1:0]     base_pbin;
  logic              nxt_ovf;
  logic [DATLEN-1:0] nxt_max;
  logic [BW-1:0]     nxt_pbin;

  // A misplaced sof restarts the sample as bin 0 of channel 0.
  always_comb begin
    accept    = in_nd & ((state == RUN) | in_sof);
    abort     = (state == RUN) & in_nd & in_sof &
                ((bin != '0) | (ch != '0));
    eff_bin   = abort ? '0 : bin;
    eff_ch    = abort ? '0 : ch;
    first     = (eff_bin == '0);
    last      = (eff_bin == BW'(NBINS - 1));
    inc_ch    = (eff_ch == CW'(NCH - 1)) ? '0 : eff_ch + CW'(1);
    base_max  = first ? '0 : max_q;
    base_pbin = first ? BW'(BIN_LO) : pbin;
    nxt_ovf   = (first ? 1'b0 : ovf) | in_ovf;
  end

  peak_cmp #(
    .DATLEN(DATLEN),
    .BW    (BW),
    .BIN_LO(BIN_LO),
    .BIN_HI(BIN_HI)
  ) u_cmp (
    .bin     (eff_bin),
    .data    (in_data),
    .cur_max (base_max),
    .cur_pbin(base_pbin),
    .nxt_max (nxt_max),
    .nxt_pbin(nxt_pbin)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SYNC;
      bin       <= '0;
      ch        <= '0;
      max_q     <= '0;
      pbin      <= BW'(BIN_LO);
      ovf       <= 1'b0;
      out_max   <= '0;
      out_bin   <= '0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (accept) begin
        state     <= RUN;
        max_q     <= nxt_max;
        pbin      <= nxt_pbin;
        ovf       <= nxt_ovf;
        frame_err <= abort;
        if (last) begin
          bin       <= '0;
          ch        <= inc_ch;
          out_max   <= nxt_max;
          out_bin   <= nxt_pbin;
          out_ch    <= eff_ch;
          out_ovf   <= nxt_ovf;
          out_valid <= 1'b1;
        end else begin
          bin <= eff_bin + BW'(1);
          ch  <= eff_ch;
        end
      end else if (state == RUN) begin
        ovf <= ovf | in_ovf;
      end
    end
  end

endmodule

// File: tb/tb_peak_track.sv
// Scoreboard bench for peak_track with NBINS=8, window 1..3.
// Directed frames with hand values plus a gapped random run.
module tb_peak_track;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] in_data;
  logic        in_nd;
  logic        in_sof;
  logic        in_ovf;
  logic [11:0] out_max;
  logic [2:0]  out_bin;
  logic [0:0]  out_ch;
  logic        out_ovf;
  logic        out_valid;
  logic        frame_err;

  peak_track #(
    .DATLEN(12),
    .NBINS (8),
    .NCH   (2),
    .BIN_LO(1),
    .BIN_HI(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_nd    (in_nd),
    .in_sof   (in_sof),
    .in_ovf   (in_ovf),
    .out_max  (out_max),
    .out_bin  (out_bin),
    .out_ch   (out_ch),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [11:0] mx;
    logic [2:0]  bn;
    logic        ch;
    logic        ov;
    int          cyc;
  } exp_t;

  typedef logic [11:0] frame_t [8];

  exp_t oq[$];
  int   eq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (out_valid) begin
      n_chk++;
      if (oq.size() == 0) begin
        $display("FAIL out_valid: pulse at cycle %0d, required none", cyc);
      end else begin
        e = oq.pop_front();
        if (out_max === e.mx && out_bin === e.bn && out_ch === e.ch &&
            out_ovf === e.ov && cyc == e.cyc)
          n_pass++;
        else
          $display("FAIL frame: got max=%0d bin=%0d ch=%0d ovf=%0d cyc=%0d, required max=%0d bin=%0d ch=%0d ovf=%0d cyc=%0d",
                   out_max, out_bin, out_ch, out_ovf, cyc,
                   e.mx, e.bn, e.ch, e.ov, e.cyc);
      end
    end
    if (frame_err) begin
      n_chk++;
      if (eq.size() == 0) begin
        $display("FAIL frame_err: pulse at cycle %0d, required none", cyc);
      end else begin
        ec = eq.pop_front();
        if (cyc == ec) n_pass++;
        else $display("FAIL frame_err: at cycle %0d, required %0d", cyc, ec);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask

  task automatic push(input logic [11:0] m, input logic [2:0] b,
                      input logic h, input logic o, input int c);
    exp_t e;
    e.mx = m; e.bn = b; e.ch = h; e.ov = o; e.cyc = c;
    oq.push_back(e);
  endtask

  task automatic send(input logic [11:0] d, input bit sof,
                      input bit ov, output int c);
    in_data = d; in_nd = 1'b1; in_sof = sof; in_ovf = ov;
    @(posedge clk); #1;
    c = cyc;
  endtask

  task automatic idle(input bit ov);
    in_nd = 1'b0;
    in_data = 12'($urandom_range(0, 4095));
    in_sof = 1'($urandom_range(0, 1));
    in_ovf = ov;
    @(posedge clk); #1;
    in_ovf = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic run_frame(input frame_t d, input bit sof, input bit gaps,
                           input int ovgap, output int c, output bit ov);
    bit o;
    ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          o = (i > 0) && ($urandom_range(0, 7) == 0);
          ov |= o;
          idle(o);
        end
      end
      if (i == ovgap) begin
        idle(1'b1);
        ov = 1'b1;
      end
      o = gaps && (i > 0) && ($urandom_range(0, 15) == 0);
      ov |= o;
      send(d[i], (i == 0) && sof, o, c);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_max"}, int'(out_max), 0);
    chk({tag, " out_bin"}, int'(out_bin), 0);
    chk({tag, " out_ch"}, int'(out_ch), 0);
    chk({tag, " out_ovf"}, int'(out_ovf), 0);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " frame_err"}, int'(frame_err), 0);
  endtask

  initial begin
    frame_t      fr;
    int          c;
    bit          ov;
    logic [11:0] mx;
    logic [2:0]  pb;
    reset_n = 1'b0;
    in_data = '0; in_nd = 1'b0; in_sof = 1'b0; in_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    idle(1'b0);

    // samples before any sof are ignored
    for (int i = 0; i < 5; i++) send(12'd77, 1'b0, 1'b1, c);
    idle(1'b0);

    fr = '{12'd5, 12'd9, 12'd9, 12'd4, 12'd20, 12'd0, 12'd0, 12'd0};
    run_frame(fr, 1'b1, 1'b0, -1, c, ov);
    push(12'd9, 3'd1, 1'b0, 1'b0, c);
    idle(1'b0);

    fr = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7};
    run_frame(fr, 1'b0, 1'b0, -1, c, ov);
    push(12'd3, 3'd3, 1'b1, 1'b0, c);
    idle(1'b0);

    // three contiguous frames
    fr = '{12'd4, 12'd0, 12'd7, 12'd7, 12'd2, 12'd9, 12'd9, 12'd9};
    run_frame(fr, 1'b1, 1'b0, -1, c, ov);
    push(12'd7, 3'd2, 1'b0, 1'b0, c);
    fr = '{12'd12, 12'd2, 12'd10, 12'd11, 12'd15, 12'd0, 12'd0, 12'd1};
    run_frame(fr, 1'b0, 1'b0, -1, c, ov);
    push(12'd11, 3'd3, 1'b1, 1'b0, c);
    fr = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    run_frame(fr, 1'b1, 1'b0, -1, c, ov);
    push(12'd0, 3'd1, 1'b0, 1'b0, c);
    idle(1'b0);

    // overflow seen only on a gap cycle
    fr = '{12'd0, 12'd5, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    run_frame(fr, 1'b0, 1'b0, 3, c, ov);
    push(12'd5, 3'd1, 1'b1, 1'b1, c);
    fr = '{12'd0, 12'd0, 12'd6, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    run_frame(fr, 1'b1, 1'b0, -1, c, ov);
    push(12'd6, 3'd2, 1'b0, 1'b0, c);
    idle(1'b0);

    // sof at bin 5 aborts and restarts
    for (int i = 0; i < 5; i++) send(12'd50, 1'b0, 1'b0, c);
    send(12'd0, 1'b1, 1'b0, c);
    eq.push_back(c);
    send(12'd1, 1'b0, 1'b0, c);
    send(12'd2, 1'b0, 1'b0, c);
    send(12'd8, 1'b0, 1'b0, c);
    for (int i = 0; i < 4; i++) send(12'd3, 1'b0, 1'b0, c);
    push(12'd8, 3'd3, 1'b0, 1'b0, c);
    idle(1'b0);

    // reset mid-frame at bin 4
    for (int i = 0; i < 4; i++) send(12'd100, 1'b0, 1'b0, c);
    in_nd = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) send(12'd200, 1'b0, 1'b0, c);
    idle(1'b0);
    chk("sync max", int'(out_max), 0);
    fr = '{12'd3, 12'd1, 12'd4, 12'd1, 12'd5, 12'd9, 12'd2, 12'd6};
    run_frame(fr, 1'b1, 1'b0, -1, c, ov);
    push(12'd4, 3'd2, 1'b0, 1'b0, c);
    idle(1'b0);

    // gapped random frames against a plain reference
    for (int f = 1; f <= 1000; f++) begin
      for (int i = 0; i < 8; i++)
        fr[i] = ($urandom_range(0, 3) == 0) ?
                12'($urandom_range(2048, 4095)) :
                12'($urandom_range(0, 15));
      mx = '0;
      pb = 3'd1;
      for (int i = 1; i <= 3; i++)
        if (fr[i] > mx) begin
          mx = fr[i];
          pb = 3'(i);
        end
      run_frame(fr, (f % 2) == 0, 1'b1, -1, c, ov);
      push(mx, pb, 1'(f % 2), ov, c);
    end

    repeat (5) idle(1'b0);
    chk("frames left", oq.size(), 0);
    chk("errs left", eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/peak_track.md
PEAK_TRACK -- requirements
Module: peak_track

Interface
REQ-001 Parameter DATLEN, default 12: bit width of magnitude samples and of the reported maximum.
REQ-002 Parameter NBINS, default 64: FFT bins per frame; power of two, at least 4.
REQ-003 Parameter NCH, default 2: wavelength channels per sweep; channel 0 is 730 nm and channel 1 is 850 nm.
REQ-004 Parameters BIN_LO, default 1, and BIN_HI, default NBINS/2-1: inclusive search window; 0 <= BIN_LO <= BIN_HI <= NBINS-1.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 reset_n  in  1  asynchronous reset, active-low.
REQ-007 in_data  in  DATLEN  unsigned FFT magnitude sample; not two's complement.
REQ-008 in_nd  in  1  in_data valid this cycle; a sample is accepted on each cycle in_nd=1.
REQ-009 in_sof  in  1  qualified by in_nd; marks bin 0 of a channel-0 frame (start of sweep).
REQ-010 in_ovf  in  1  FFT overflow indication; sampled every cycle.
REQ-011 out_max  out  DATLEN  peak magnitude of the last completed frame.
REQ-012 out_bin  out  clog2(NBINS)  bin index of that peak.
REQ-013 out_ch  out  clog2(NCH), minimum 1  channel of that frame.
REQ-014 out_ovf  out  1  in_ovf was seen during that frame.
REQ-015 out_valid  out  1  single-cycle pulse; the out_* fields are new.
REQ-016 frame_err  out  1  single-cycle pulse; a frame was aborted.

Function
REQ-017 The block SHALL have two states, SYNC and RUN; reset enters SYNC.
REQ-018 In SYNC it SHALL ignore samples until in_nd=1 with in_sof=1, then enter RUN with bin=0 and ch=0; that sample SHALL be processed as bin 0.
REQ-019 In RUN each accepted sample SHALL have index bin; bin increments by 1 per accepted sample and wraps NBINS-1 -> 0.
REQ-020 On each wrap ch SHALL increment and wrap NCH-1 -> 0.
REQ-021 At bin 0 the accumulator SHALL load max=0, pbin=BIN_LO and ovf=0.
REQ-022 For bins in [BIN_LO, BIN_HI], in_data > max (strict, unsigned) SHALL update max and pbin; ties keep the lower bin.
REQ-023 Samples outside the window SHALL NOT affect max or pbin.
REQ-024 in_ovf=1 on any cycle while in RUN SHALL set the frame's ovf flag, including cycles where in_nd=0.
REQ-025 Acceptance of bin NBINS-1 SHALL cause, on the next rising edge, out_max/out_bin/out_ch/out_ovf to register the final values (including that sample) and out_valid=1 for exactly one cycle.
REQ-026 Outputs SHALL hold until the next out_valid.
REQ-027 Back-to-back frames with in_nd continuously high SHALL lose no samples; emission SHALL overlap the next frame's bin 0.
REQ-028 in_sof with in_nd in RUN at bin != 0, or at bin 0 with ch != 0, SHALL abort the current frame: no out_valid, frame_err pulses next cycle, and the sample restarts as bin 0, ch 0.
REQ-029 in_sof at bin 0 with ch=0 SHALL be normal operation.
REQ-030 Gaps (in_nd=0) SHALL freeze bin, ch and the accumulator.

Reset
REQ-031 reset_n=0 SHALL immediately force SYNC, bin=0, ch=0, max=0, pbin=BIN_LO, ovf=0, and all outputs to 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame without producing out_valid or frame_err.

Structure
REQ-033 A shared package peak_pkg SHALL hold the default DATLEN (12), the state enumeration and the clog2-derived width constants.
REQ-034 A sub-module peak_cmp (window test plus strict compare and update) is natural, one instance.
REQ-035 There SHALL be no internal memory; the block SHALL be register-only.

Verification
REQ-036 NBINS=8, window 1..3, sof then data 5,9,9,4,20,0,0,0 -> out_valid one cycle after the 8th sample; out_max=9, out_bin=1, out_ch=0, out_ovf=0.
REQ-037 Two contiguous frames with peaks 7@2 then 11@3 -> two pulses exactly 8 cycles apart; out_ch=0 then 1; the third frame reports out_ch=0.
REQ-038 in_ovf pulsed once with in_nd=0 mid-frame -> that frame's out_ovf=1; the next frame's out_ovf=0.
REQ-039 sof at bin 5 -> frame_err pulse; no out_valid; the following 8 samples give out_valid with out_ch=0.
REQ-040 Samples before the first sof, and reset_n low at bin 4 -> no output; all outputs 0; after release, SYNC waits for sof.
REQ-041 Random in_nd gaps at 50% duty versus a reference model -> all fields match across 1000 frames.
